// File: rtl/tick_divider_multi.sv
// tick_divider_multi: NCH independent programmable clock dividers emitting one-cycle ticks.
// Define TICK_DIV_SQUARE_EN to add the per-channel square-wave output sq.
module tick_divider_multi #(
   parameter int NCH     = 4,
   parameter int W       = 27,
   parameter int DIV_DEF = 1000,
   localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] en,
   input  logic [NCH-1:0] clr,
   input  logic           cfg_we,
   input  logic [CW-1:0]  cfg_ch,
   input  logic [W-1:0]   cfg_div,
   output logic [NCH-1:0] tick,
   output logic           cfg_err
`ifdef TICK_DIV_SQUARE_EN
   ,
   output logic [NCH-1:0] sq
`endif
);

   localparam logic [W-1:0]  DIV_RST = W'(DIV_DEF);
   localparam logic [W-1:0]  ONE_W   = W'(1);
   localparam logic [31:0]   NCH_U   = 32'(NCH);

   logic [W-1:0]   div_q   [NCH];
   logic [W-1:0]   count_q [NCH];
   logic [31:0]    ch_ext;
   logic           cfg_ok;
   logic           cfg_bad;
   logic [NCH-1:0] wr_sel;

   // Config port is a bare strobe with no back-pressure: every cycle with cfg_we=1 is
   // one request, either applied at that edge or reported on cfg_err one cycle later.
   always_comb begin
      ch_ext  = 32'(cfg_ch);
      cfg_ok  = cfg_we && (ch_ext < NCH_U) && (cfg_div != '0);
      cfg_bad = cfg_we && !cfg_ok;
      wr_sel  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         wr_sel[i] = cfg_ok && (ch_ext == i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NCH; i++) begin
            div_q[i]   <= DIV_RST;
            count_q[i] <= '0;
         end
         tick    <= '0;
         cfg_err <= 1'b0;
`ifdef TICK_DIV_SQUARE_EN
         sq      <= '0;
`endif
      end else begin
         cfg_err <= cfg_bad;
         for (int i = 0; i < NCH; i++) begin
            if (wr_sel[i]) begin
               div_q[i]   <= cfg_div;
               count_q[i] <= '0;
               tick[i]    <= 1'b0;
`ifdef TICK_DIV_SQUARE_EN
               sq[i]      <= 1'b0;
`endif
            end else if (clr[i]) begin
               count_q[i] <= '0;
               tick[i]    <= 1'b0;
`ifdef TICK_DIV_SQUARE_EN
               sq[i]      <= 1'b0;
`endif
            end else if (en[i]) begin
               // count runs 0..div-1, so the tick lands on the div-th enabled edge
               if (count_q[i] == div_q[i] - ONE_W) begin
                  count_q[i] <= '0;
                  tick[i]    <= 1'b1;
`ifdef TICK_DIV_SQUARE_EN
                  sq[i]      <= ~sq[i];
`endif
               end else begin
                  count_q[i] <= count_q[i] + ONE_W;
                  tick[i]    <= 1'b0;
               end
            end else begin
               tick[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_tick_divider_multi.sv
// Scoreboard bench for tick_divider_multi: a 4-channel instance plus a 3-channel instance
// (the latter exercises out-of-range channel writes). Honours TICK_DIV_SQUARE_EN.
`timescale 1ns/1ps
module tb_tick_divider_multi;

   localparam int NCH  = 4;
   localparam int W    = 27;
   localparam int DEF  = 1000;
   localparam int NCH3 = 3;
   localparam int W3   = 8;
   localparam int DEF3 = 4;
`ifdef TICK_DIV_SQUARE_EN
   localparam int EW  = 2*NCH + 1;
   localparam int EW3 = 2*NCH3 + 1;
`else
   localparam int EW  = NCH + 1;
   localparam int EW3 = NCH3 + 1;
`endif

   logic            clk;
   logic            rst;
   logic [NCH-1:0]  en;
   logic [NCH-1:0]  clr;
   logic            cfg_we;
   logic [1:0]      cfg_ch;
   logic [W-1:0]    cfg_div;
   logic [NCH-1:0]  tick;
   logic            cfg_err;
   logic [NCH3-1:0] tick3;
   logic            cfg_err3;
   logic [EW-1:0]   act;
   logic [EW3-1:0]  act3;
`ifdef TICK_DIV_SQUARE_EN
   logic [NCH-1:0]  sq;
   logic [NCH3-1:0] sq3;
   assign act  = {sq, cfg_err, tick};
   assign act3 = {sq3, cfg_err3, tick3};
`else
   assign act  = {cfg_err, tick};
   assign act3 = {cfg_err3, tick3};
`endif

   tick_divider_multi #(.NCH(NCH), .W(W), .DIV_DEF(DEF)) u_dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
      .cfg_div(cfg_div), .tick(tick), .cfg_err(cfg_err)
`ifdef TICK_DIV_SQUARE_EN
      , .sq(sq)
`endif
   );

   tick_divider_multi #(.NCH(NCH3), .W(W3), .DIV_DEF(DEF3)) u_dut3 (
      .clk(clk), .rst(rst), .en(en[NCH3-1:0]), .clr(clr[NCH3-1:0]), .cfg_we(cfg_we),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div[W3-1:0]), .tick(tick3), .cfg_err(cfg_err3)
`ifdef TICK_DIV_SQUARE_EN
      , .sq(sq3)
`endif
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // scoreboard state
   logic [EW-1:0]  exp_q[$];
   logic [EW3-1:0] exp3_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit chk_on   = 1'b0;
   int tick_cnt  [NCH];
   int tick_cnt3 [NCH3];

   // reference model: per channel, enabled cycles still to wait until the next tick
   int m_div  [2][NCH];
   int m_left [2][NCH];
   bit m_sq   [2][NCH];
   int nch_of [2] = '{NCH, NCH3};
   int def_of [2] = '{DEF, DEF3};

   task automatic model_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < NCH; i++) begin
            m_div[k][i]  = def_of[k];
            m_left[k][i] = def_of[k];
            m_sq[k][i]   = 1'b0;
         end
   endtask

   task automatic model_step(input int k, output logic [NCH-1:0] t, output logic e);
      int dv;
      bit ok;
      dv = (k == 0) ? int'(cfg_div) : int'(cfg_div[W3-1:0]);
      ok = cfg_we && (int'(cfg_ch) < nch_of[k]) && (dv != 0);
      e  = cfg_we && !ok;
      t  = '0;
      for (int i = 0; i < nch_of[k]; i++) begin
         if (ok && int'(cfg_ch) == i) begin
            m_div[k][i]  = dv;
            m_left[k][i] = dv;
            m_sq[k][i]   = 1'b0;
         end else if (clr[i]) begin
            m_left[k][i] = m_div[k][i];
            m_sq[k][i]   = 1'b0;
         end else if (en[i]) begin
            m_left[k][i]--;
            if (m_left[k][i] == 0) begin
               t[i]         = 1'b1;
               m_left[k][i] = m_div[k][i];
               m_sq[k][i]   = !m_sq[k][i];
            end
         end
      end
   endtask

   // driver: called at a falling edge; drives one cycle of inputs and queues the result
   task automatic cycle(input logic [NCH-1:0] e_in, input logic [NCH-1:0] c_in,
                        input logic we, input logic [1:0] ch, input int dv);
      logic [NCH-1:0] t0, t1;
      logic           e0, e1;
`ifdef TICK_DIV_SQUARE_EN
      logic [NCH-1:0] s0, s1;
`endif
      en = e_in; clr = c_in; cfg_we = we; cfg_ch = ch; cfg_div = W'(dv);
      model_step(0, t0, e0);
      model_step(1, t1, e1);
`ifdef TICK_DIV_SQUARE_EN
      for (int i = 0; i < NCH; i++) begin
         s0[i] = m_sq[0][i];
         s1[i] = m_sq[1][i];
      end
      exp_q.push_back({s0, e0, t0});
      exp3_q.push_back({s1[NCH3-1:0], e1, t1[NCH3-1:0]});
`else
      exp_q.push_back({e0, t0});
      exp3_q.push_back({e1, t1[NCH3-1:0]});
`endif
      @(negedge clk);
   endtask

   task automatic run(input logic [NCH-1:0] e_in, input int n);
      for (int j = 0; j < n; j++) cycle(e_in, '0, 1'b0, 2'd0, 0);
   endtask

   task automatic check_zero(input string name);
      n_checks++;
      if (act !== '0 || act3 !== '0) begin
         n_fail++;
         $display("FAIL %s t=%0t act=%h act3=%h required=0", name, $time, act, act3);
      end
   endtask

   // monitor: every checked cycle the DUTs present their registered outputs
   always @(posedge clk) begin
      #1;
      cyc++;
      if (chk_on) begin
         if (exp_q.size() == 0 || exp3_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty cyc=%0d", cyc);
         end else begin
            logic [EW-1:0]  ex;
            logic [EW3-1:0] ex3;
            ex  = exp_q.pop_front();
            ex3 = exp3_q.pop_front();
            n_checks++;
            if (act !== ex) begin
               n_fail++;
               $display("FAIL main_out cyc=%0d act=%h exp=%h", cyc, act, ex);
            end
            n_checks++;
            if (act3 !== ex3) begin
               n_fail++;
               $display("FAIL nch3_out cyc=%0d act=%h exp=%h", cyc, act3, ex3);
            end
         end
         for (int i = 0; i < NCH; i++) tick_cnt[i] += int'(tick[i]);
         for (int i = 0; i < NCH3; i++) tick_cnt3[i] += int'(tick3[i]);
      end
   end

   initial begin
      int guard;
      rst = 1'b0; en = '0; clr = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");

      // release and free-run with default divisors
      rst = 1'b1;
      model_reset();
      chk_on = 1'b1;
      for (int i = 0; i < NCH; i++) tick_cnt[i] = 0;
      for (int i = 0; i < NCH3; i++) tick_cnt3[i] = 0;
      run(4'b1111, 5000);
      for (int i = 0; i < NCH; i++) begin
         n_checks++;
         if (tick_cnt[i] != 5) begin
            n_fail++;
            $display("FAIL tick_count_ch%0d act=%0d required=5", i, tick_cnt[i]);
         end
      end
      for (int i = 0; i < NCH3; i++) begin
         n_checks++;
         if (tick_cnt3[i] != 5000 / DEF3) begin
            n_fail++;
            $display("FAIL tick_count3_ch%0d act=%0d required=%0d", i, tick_cnt3[i], 5000 / DEF3);
         end
      end

      // mid-count rewrite of ch2, pause of ch1 at count 400
      run(4'b1111, 400);
      cycle(4'b1101, '0, 1'b1, 2'd2, 5);
      run(4'b1101, 299);
      run(4'b1111, 700);

      // write beats clr on the same channel, then clr alone at count 999
      cycle(4'b1111, 4'b0001, 1'b1, 2'd0, 3);
      guard = 0;
      while (m_left[0][3] != 1 && guard < 2000) begin
         cycle(4'b1111, '0, 1'b0, 2'd0, 0);
         guard++;
      end
      cycle(4'b1111, 4'b1000, 1'b0, 2'd0, 0);
      run(4'b1111, 1005);

      // rejected writes, back-to-back, and div=1
      cycle(4'b1111, '0, 1'b1, 2'd1, 0);
      cycle(4'b1111, '0, 1'b1, 2'd2, 0);
      run(4'b1111, 2);
      cycle(4'b1111, '0, 1'b1, 2'd3, 7);
      run(4'b1111, 3);
      cycle(4'b1111, '0, 1'b1, 2'd1, 1);
      run(4'b1111, 20);
      run(4'b1010, 10);

      // randomized traffic with small divisors
      for (int j = 0; j < 3000; j++) begin
         logic [NCH-1:0] e_r, c_r;
         for (int i = 0; i < NCH; i++) begin
            e_r[i] = ($urandom_range(0, 7) != 0);
            c_r[i] = ($urandom_range(0, 31) == 0);
         end
         cycle(e_r, c_r, ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
               int'($urandom_range(0, 9)));
      end

      // all ticks and cfg_err high, then asynchronous reset between clock edges
      for (int i = 0; i < NCH; i++) cycle(4'b1111, '0, 1'b1, 2'(i), 1);
      run(4'b1111, 3);
      cycle(4'b1111, '0, 1'b1, 2'd0, 0);
      chk_on = 1'b0;
      #2 rst = 1'b0;
      #1 check_zero("async_reset");
      repeat (2) @(negedge clk);
      check_zero("reset_hold");
      rst = 1'b1;
      model_reset();
      exp_q.delete();
      exp3_q.delete();
      chk_on = 1'b1;
      run(4'b1111, 1001);
      cycle(4'b0000, '0, 1'b0, 2'd0, 0);
      chk_on = 1'b0;

      n_checks++;
      if (exp_q.size() != 0 || exp3_q.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_expected act=%0d required=0", exp_q.size() + exp3_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tick_divider_multi.md
# tick_divider_multi

Multi-channel, runtime-programmable tick generator for the smart-watch timebase. Each of NCH independent channels divides the system clock by its own divisor register and emits one-cycle tick pulses. Per-channel enable and synchronous restart are provided, and divisors can be rewritten at run time through a single write port. It replaces fixed single-ratio dividers that feed the 1 kHz display scan, the 100 Hz stopwatch and the 1 Hz clock domains.

## Interface
Parameters:
- NCH, 4: number of channels (1..16).
- W, 27: divisor and counter width per channel; legal divisors are 1..2^W-1.
- DIV_DEF, 1000: reset value of every channel's divisor register. Must satisfy 1 ≤ DIV_DEF < 2^W.

Ports:
- clk  in  1  system clock; all logic updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  NCH  per-channel count enable.
- clr  in  NCH  per-channel synchronous restart.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  max(1,$clog2(NCH))  channel index for the write.
- cfg_div  in  W  new divisor value.
- tick  out  NCH  per-channel one-cycle tick, registered.
- cfg_err  out  1  one-cycle pulse flagging a rejected write, registered.
- sq  out  NCH  square-wave output, registered; present only with TICK_DIV_SQUARE_EN.

## Operation
- Reset (rst=0): every count=0, every div=DIV_DEF, tick=0, cfg_err=0, sq=0. The reset takes effect immediately and clears any period in progress.
- Per-channel priority each cycle, highest first: config write to this channel, then clr, then en, then idle.
- Config write (cfg_we=1, cfg_ch<NCH, cfg_div≠0):
  - div[cfg_ch] ← cfg_div, count ← 0, tick ← 0.
  - The new period starts on the next cycle.
  - Other channels are unaffected.
- Rejected write (cfg_we=1 with cfg_ch≥NCH or cfg_div=0):
  - No register changes.
  - cfg_err=1 for exactly one cycle.
  - All channels continue undisturbed.
- clr=1: count ← 0, tick ← 0. The divisor is kept.
- en=1 with no write and no clr:
  - If count==div-1: count ← 0, tick ← 1.
  - Otherwise: count ← count+1, tick ← 0.
- en=0: count holds, tick ← 0. The channel pauses and resumes mid-period without losing phase.
- div=1: tick is high on every enabled cycle.
- Counter arithmetic is W bits. Count never exceeds div-1, so there is no wrap beyond the divisor.
- A write that lowers div below the current count is safe, because count is zeroed by the write.

## Timing
- Starting from count=0 with en held at 1, tick rises after exactly div rising edges.
- After that, tick repeats with period div cycles and is high for 1 cycle.
- After a write at edge N, the first tick occurs at edge N+div'. Here div' is the new divisor and en is held at 1.
- cfg_err asserts on the edge after the rejected strobe is sampled.
- cfg_err is high for one cycle per rejected strobe. Back-to-back bad strobes hold it high on consecutive cycles.
- Combinational input-to-output paths: none. Every output comes from a flop.

## Configuration
- Macro: TICK_DIV_SQUARE_EN.
- Defined:
  - Port sq[NCH] exists.
  - sq[i] toggles on every cycle in which tick[i] is registered high, giving a period of 2·div cycles.
  - clr and config writes force sq[i] to 0.
  - Reset drives sq to 0.
- Undefined: the sq port and its flops are absent. tick behaviour is identical to the defined case.

## Test plan
- NCH=4, DIV_DEF=1000, en=4'b1111 after reset release: each tick is first high after 1000 edges, then every 1000 cycles, width 1. 5000 cycles yield exactly 5 ticks per channel.
- Write cfg_ch=2, cfg_div=5 while channel 2 is mid-count:
  - tick[2] rises 5 edges after the write, then repeats every 5 cycles.
  - Channels 0, 1 and 3 keep their original 1000-cycle phase.
- Drop en[1] for 300 cycles at count=400, then restore it: the next tick[1] occurs 600 enabled cycles later (the 300-cycle pause extends the period).
- Simultaneous cfg_we (ch=0, div=3) and clr[0]=1: the write wins, so div[0]=3 and count=0. Then assert clr[3] alone at count 999: tick[3] stays 0 and the next tick[3] comes 1000 cycles later.
- Rejected writes:
  - cfg_div=0 gives cfg_err high for 1 cycle and no divisor change.
  - With NCH=3, cfg_ch=3 gives cfg_err=1 and all ticks undisturbed.
  - cfg_div=1 gives tick high on every enabled cycle.
- Assert rst low mid-period: outputs go to 0 asynchronously without waiting for clk. After release, all divisors read back as DIV_DEF by timing, with the first tick at 1000 edges. With TICK_DIV_SQUARE_EN and div=4, sq toggles every 4 cycles (period 8).
